// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, default widths
// and the sequencer state encoding.
package cpu_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] LOAD  = 3'b001;
  localparam logic [2:0] STORE = 3'b010;
  localparam logic [2:0] ADD   = 3'b011;
  localparam logic [2:0] SUB   = 3'b100;
  localparam logic [2:0] JMP   = 3'b101;
  localparam logic [2:0] JZ    = 3'b110;
  localparam logic [2:0] OUT   = 3'b111;

  typedef enum logic [2:0] {
    FETCH_REQ = 3'd0,
    FETCH_LAT = 3'd1,
    EXEC      = 3'd2,
    MEM_WB    = 3'd3,
    UART_WAIT = 3'd4,
    HALT      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns pc and ir and times the strobes.
// Optional CPU_SEQ_SINGLE_STEP_EN adds a step port gating each fetch.
//
// state     | meaning
// FETCH_REQ | rom_addr = pc, wait for run (and step)
// FETCH_LAT | ROM data valid, latch into ir
// EXEC      | decoder controls valid, issue ram_re/ram_we/uart_valid
// MEM_WB    | RAM data consumed, acc_we pulse, pc+1
// UART_WAIT | hold uart_valid and ir until uart_ready
// HALT      | jump-to-self seen, frozen until reset
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  input  logic              dec_mem_read,
  input  logic              dec_acc_write,
  input  logic              dec_mem_write,
  input  logic              dec_pc_write,
  input  logic              dec_uart_send,
  input  logic [ADDR_W-1:0] dec_new_pc,
  output logic              ram_re,
  output logic              ram_we,
  output logic              acc_we,
  output logic              uart_valid,
  input  logic              uart_ready,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  output logic              halted,
  input  logic              step
`else
  output logic              halted
`endif
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W-1:0] ir_q;
  logic              acc_we_q;
  logic              halted_q;
  logic              go;

  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign go = run & step;
`else
  assign go = run;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH_REQ;
      pc_q     <= '0;
      ir_q     <= '0;
      acc_we_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      acc_we_q <= 1'b0;
      unique case (state_q)
        FETCH_REQ: if (go) state_q <= FETCH_LAT;
        FETCH_LAT: begin
          ir_q    <= rom_data;
          state_q <= EXEC;
        end
        EXEC: begin
          if (dec_mem_read) begin
            state_q  <= MEM_WB;
            acc_we_q <= dec_acc_write;
          end else if (dec_uart_send && !uart_ready) begin
            state_q <= UART_WAIT;
          end else if (dec_pc_write) begin
            pc_q <= dec_new_pc;
            // A jump onto its own address is the program's halt idiom.
            if (dec_new_pc == pc_q) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= FETCH_REQ;
            end
          end else begin
            pc_q    <= pc_inc;
            state_q <= FETCH_REQ;
          end
        end
        MEM_WB: begin
          pc_q    <= pc_inc;
          state_q <= FETCH_REQ;
        end
        UART_WAIT: begin
          if (uart_ready) begin
            pc_q    <= pc_inc;
            state_q <= FETCH_REQ;
          end
        end
        HALT: state_q <= HALT;
        default: state_q <= FETCH_REQ;
      endcase
    end
  end

  // EXEC strobes depend only on state and the decoder, never on uart_ready.
  assign ram_re     = (state_q == EXEC) && dec_mem_read;
  assign ram_we     = (state_q == EXEC) && dec_mem_write && !dec_mem_read;
  assign uart_valid = ((state_q == EXEC) && dec_uart_send && !dec_mem_read) ||
                      (state_q == UART_WAIT);
  assign acc_we     = acc_we_q;
  assign halted     = halted_q;
  assign rom_addr   = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a synchronous ROM and decoder model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] ir;
  logic [AW-1:0] pc;
  logic          dec_mem_read, dec_acc_write, dec_mem_write;
  logic          dec_pc_write, dec_uart_send;
  logic [AW-1:0] dec_new_pc;
  logic          ram_re, ram_we, acc_we, uart_valid;
  logic          uart_ready = 1'b0;
  logic          halted;
  logic          step = 1'b1;
  logic          zflag = 1'b0;

  logic [DW-1:0] rom [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always_comb begin
    dec_mem_read  = 1'b0;
    dec_acc_write = 1'b0;
    dec_mem_write = 1'b0;
    dec_pc_write  = 1'b0;
    dec_uart_send = 1'b0;
    dec_new_pc    = ir[4:0];
    case (ir[7:5])
      LOAD, ADD, SUB: begin
        dec_mem_read  = 1'b1;
        dec_acc_write = 1'b1;
      end
      STORE:   dec_mem_write = 1'b1;
      JMP:     dec_pc_write  = 1'b1;
      JZ:      dec_pc_write  = zflag;
      OUT:     dec_uart_send = 1'b1;
      default: ;
    endcase
  end

  cpu_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .ir           (ir),
    .pc           (pc),
    .dec_mem_read (dec_mem_read),
    .dec_acc_write(dec_acc_write),
    .dec_mem_write(dec_mem_write),
    .dec_pc_write (dec_pc_write),
    .dec_uart_send(dec_uart_send),
    .dec_new_pc   (dec_new_pc),
    .ram_re       (ram_re),
    .ram_we       (ram_we),
    .acc_we       (acc_we),
    .uart_valid   (uart_valid),
    .uart_ready   (uart_ready),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .halted       (halted),
    .step         (step)
`else
    .halted       (halted)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strobes packed as {ram_re, ram_we, acc_we, uart_valid}
  function automatic logic [31:0] strb();
    return {28'd0, ram_re, ram_we, acc_we, uart_valid};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h00;
    rom[1] = {LOAD, 5'd5};
    rom[2] = {OUT, 5'd0};
    rom[3] = {JMP, 5'd3};

    // reset values, and run=0 holds in FETCH_REQ
    tick(); tick();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", strb(), 0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("run0_pc", pc, 0);
    chk("run0_ir", ir, 0);

    // NOP: 3 cycles, no strobes
    run = 1'b1;
    tick();
    chk("nop_lat_strobes", strb(), 0);
    tick();
    chk("nop_ir", ir, 8'h00);
    chk("nop_exec_strobes", strb(), 0);
    chk("nop_exec_pc", pc, 0);
    tick();
    chk("nop_pc", pc, 1);

    // LOAD 5: ram_re in EXEC, acc_we next cycle, 4 cycles
    tick(); tick();
    chk("load_ir", ir, 8'h25);
    chk("load_exec_strobes", strb(), 4'b1000);
    tick();
    chk("load_wb_strobes", strb(), 4'b0010);
    chk("load_wb_pc", pc, 1);
    tick();
    chk("load_pc", pc, 2);
    chk("load_done_strobes", strb(), 0);

    // OUT with ready low for 5 valid cycles, high on the 6th
    tick(); tick();
    chk("out_ir", ir, 8'hE0);
    chk("out_valid_1", uart_valid, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("out_wait_valid", uart_valid, 1);
      chk("out_wait_ir", ir, 8'hE0);
      chk("out_wait_pc", pc, 2);
    end
    tick();
    uart_ready = 1'b1;
    chk("out_valid_6", uart_valid, 1);
    chk("out_accept_pc", pc, 2);
    tick();
    uart_ready = 1'b0;
    chk("out_pc", pc, 3);
    chk("out_valid_drop", uart_valid, 0);

    // JMP 3 at pc=3: halt
    tick(); tick();
    chk("jmp_ir", ir, 8'hA3);
    chk("jmp_exec_halted", halted, 0);
    tick();
    chk("halt_set", halted, 1);
    chk("halt_pc", pc, 3);
    rom[3] = 8'h00;
    tick(); tick(); tick();
    chk("halt_sticky", halted, 1);
    chk("halt_rom_addr", rom_addr, 3);
    chk("halt_ir_frozen", ir, 8'hA3);
    chk("halt_strobes", strb(), 0);
    reset = 1'b1;
    tick();
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_pc", pc, 0);

    // JZ not taken, wrap 31->0, JZ taken, STORE, OUT with immediate ready
    rom[0] = {JZ, 5'd4};
    rom[1] = {JMP, 5'd31};
    rom[31] = 8'h00;
    rom[4] = {STORE, 5'd8};
    rom[5] = {OUT, 5'd0};
    rom[6] = {OUT, 5'd1};
    zflag = 1'b0;
    reset = 1'b0;
    tick(); tick();
    chk("jz_nt_strobes", strb(), 0);
    tick();
    chk("jz_nt_pc", pc, 1);
    tick(); tick(); tick();
    chk("jmp31_pc", pc, 31);
    tick(); tick(); tick();
    chk("wrap_pc", pc, 0);
    chk("wrap_halted", halted, 0);
    zflag = 1'b1;
    tick(); tick(); tick();
    chk("jz_t_pc", pc, 4);
    tick(); tick();
    chk("store_exec_strobes", strb(), 4'b0100);
    tick();
    chk("store_pc", pc, 5);
    chk("store_done_strobes", strb(), 0);
    uart_ready = 1'b1;
    tick(); tick();
    chk("out_rdy_valid", uart_valid, 1);
    tick();
    chk("out_rdy_pc", pc, 6);
    chk("out_rdy_valid_drop", uart_valid, 0);
    uart_ready = 1'b0;

    // reset in the middle of UART_WAIT
    tick(); tick(); tick();
    chk("uw_valid", uart_valid, 1);
    chk("uw_ir", ir, 8'hE1);
    reset = 1'b1;
    tick();
    chk("uw_rst_valid", uart_valid, 0);
    chk("uw_rst_pc", pc, 0);
    chk("uw_rst_ir", ir, 0);

    // run dropped mid-instruction: JZ 4 still completes, then hold
    reset = 1'b0;
    tick();
    run = 1'b0;
    tick(); tick();
    chk("run_drop_pc", pc, 4);
    tick(); tick(); tick();
    chk("run_drop_hold_pc", pc, 4);
    chk("run_drop_hold_ir", ir, 8'hC4);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    // step low blocks fetch even with run high
    reset = 1'b1;
    step = 1'b0;
    tick();
    reset = 1'b0;
    run = 1'b1;
    tick(); tick(); tick(); tick();
    chk("step0_pc", pc, 0);
    chk("step0_ir", ir, 0);
    step = 1'b1;
    tick(); tick(); tick();
    chk("step1_pc", pc, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
